shift_reg: RTL and testbench

// - Serial-in, parallel-out shift register with a latched output stage.
// - Sits behind the PWM channel generator. Each clock the generator presents one

---
 rtl/shift_reg.sv | 50 +++++
 tb/tb_shift_reg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/shift_reg.sv
// Serial-in, parallel-out shift register with a latched output stage.
// The output register only reloads when latch is sampled high, so pwm stays steady while a frame shifts in.
module shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             latch,
    input  logic             S_in,
    output logic [WIDTH-1:0] pwm
);

    // Declaration initialisers give the zero power-up state on FPGA targets.
    logic [WIDTH-1:0] sh_reg  = '0;
    logic [WIDTH-1:0] out_reg = '0;
    logic [WIDTH-1:0] sh_next;

    genvar gi;
    generate
        if (LSB_FIRST) begin : g_lsb_first
            // New bit enters at the MSB and walks toward bit 0.
            assign sh_next[WIDTH-1] = S_in;
            for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
                assign sh_next[gi] = sh_reg[gi+1];
            end
        end else begin : g_msb_first
            assign sh_next[0] = S_in;
            for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
                assign sh_next[gi+1] = sh_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_reg  <= '0;
            out_reg <= '0;
        end else begin
            sh_reg <= sh_next;
            // Capture the post-shift value so latch aligns with the last bit of a frame.
            if (latch) begin
                out_reg <= sh_next;
            end
        end
    end

    assign pwm = out_reg;

endmodule

// File: tb/tb_shift_reg.sv
// Scoreboard bench for shift_reg: driver pushes expected pwm per edge, monitor pops and compares.
module tb_shift_reg;

    localparam int W         = 8;
    localparam bit LSB_FIRST = 1'b1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         latch = 1'b0;
    logic         S_in = 1'b0;
    logic [W-1:0] pwm;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           tag_q[$];
    bit           hist[$];
    logic [W-1:0] model_pwm = '0;
    int           step_no = 0;

    shift_reg #(.WIDTH(W), .LSB_FIRST(LSB_FIRST)) dut (
        .clk   (clk),
        .reset (reset),
        .latch (latch),
        .S_in  (S_in),
        .pwm   (pwm)
    );

    always #5 clk = ~clk;

    // Reference: the last W bits received since reset; newest bit sits at the entry end.
    function automatic logic [W-1:0] model_frame();
        logic [W-1:0] v;
        int n;
        v = '0;
        n = hist.size();
        for (int i = 0; i < n; i++) begin
            if (LSB_FIRST) v[W-1-i] = hist[n-1-i];
            else           v[i]     = hist[n-1-i];
        end
        return v;
    endfunction

    task automatic step(input bit r, input bit l, input bit s);
        @(negedge clk);
        reset = r;
        latch = l;
        S_in  = s;
        if (r) begin
            hist.delete();
            model_pwm = '0;
        end else begin
            hist.push_back(s);
            if (hist.size() > W) void'(hist.pop_front());
            if (l) model_pwm = model_frame();
        end
        step_no++;
        exp_q.push_back(model_pwm);
        tag_q.push_back(step_no);
    endtask

    // Sends bits first..last; latch only with the final bit.
    task automatic send_frame(input logic [W-1:0] bits_first_in_lsb);
        for (int i = 0; i < W; i++) step(1'b0, (i == W - 1), bits_first_in_lsb[i]);
    endtask

    // Called right after a step: the previous edge's result is visible on pwm.
    task automatic check_pwm(input logic [W-1:0] expv, input string name);
        checks++;
        if (pwm !== expv) begin
            errors++;
            $display("FAIL %s: pwm=%h expected=%h", name, pwm, expv);
        end else begin
            $display("ok   %s: pwm=%h", name, pwm);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            int t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (pwm !== e) begin
                errors++;
                $display("FAIL step%0d: pwm=%h expected=%h", t, pwm, e);
            end
        end
    end

    initial begin
        #1;
        check_pwm(8'h00, "power_up");

        // Reset with S_in and latch high, then release.
        step(1, 1, 1);
        step(1, 1, 1);
        step(0, 0, 1);
        check_pwm(8'h00, "reset_hold");
        step(0, 0, 0);
        check_pwm(8'h00, "reset_release");

        // Frame 1,1,0,0,0,0,0,0 after a clean reset.
        step(1, 0, 0);
        send_frame(8'b0000_0011);
        step(0, 0, 1);
        check_pwm(8'h03, "frame_03");
        for (int i = 0; i < W - 2; i++) step(0, 0, 1);
        check_pwm(8'h03, "frame_hold");
        step(0, 1, 1);   // completes a frame of ones

        // Back-to-back frames with no idle cycle.
        send_frame(8'b0101_0101);
        send_frame(8'b1111_0000);
        step(0, 0, 0);
        check_pwm(8'hF0, "b2b_frameB");

        // Early latch on the third bit after reset.
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 0);
        check_pwm(8'hE0, "early_latch");

        // Latch held high while shifting ones.
        step(1, 0, 0);
        for (int i = 0; i < W; i++) step(0, 1, 1);
        step(0, 0, 0);
        check_pwm(8'hFF, "latch_held");

        // Reset mid-frame discards earlier ones.
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(1, 0, 0);
        send_frame(8'b1000_0000);
        step(0, 0, 0);
        check_pwm(8'h80, "reset_mid_frame");

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0), 1'($urandom));
        end
        step(0, 0, 0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
